tdm_demux4: RTL
===============

// Module: tdm_demux4
// PURPOSE
//  Receive-side counterpart of the 4:1 channel mux: takes a time-division-multiplexed
//  stream (one slot per accepted beat, 4 slots per frame, slot 0 marked by frame_sync)
//  and rebuilds four parallel channels. A 2-bit slot counter plays the role of the
//  mux select {s1,s0}. Sits downstream of the serial link, ahead of per-channel logic.
// PARAMETERS
//  WIDTH  1  bits per slot (per channel sample)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  din_valid   in   1      din/frame_sync valid this cycle (one beat = one slot)
//  din         in   WIDTH  slot data
//  frame_sync  in   1      qualified by din_valid; marks slot 0 of a frame
//  o0..o3      out  WIDTH  each is a registered channel sample (slot 0..3 of the last complete frame)
//  out_valid   out  1      1-cycle pulse: o0..o3 just updated with a new frame
//  slot        out  2      {s1,s0}: slot index expected for the next beat
//  locked      out  1      1 while in LOCKED state
//  sync_err    out  1      1-cycle pulse on frame-alignment error
// BEHAVIOUR
//  Reset (async, rst_n=0): o0..o3=0, out_valid=0, slot=0, locked=0, sync_err=0,
//   capture regs cleared, state=HUNT. Reset mid-frame discards the partial frame.
//  Beats without din_valid are ignored entirely (counter, state and regs hold).
//  FSM:
//   HUNT: beat with frame_sync=1 -> store din as slot 0, slot<=1, go LOCKED.
//         beat with frame_sync=0 -> discarded, no error, stay HUNT.
//   LOCKED, expected slot k:
//    k!=0, frame_sync=0 -> store din in capture reg k, slot<=k+1 (3 wraps to 0).
//    k!=0, frame_sync=1 -> early sync: sync_err pulse, partial frame dropped (no
//         out_valid), beat taken as slot 0 of new frame, slot<=1, stay LOCKED.
//    k==0, frame_sync=1 -> normal: store slot 0, slot<=1.
//    k==0, frame_sync=0 -> lost sync: sync_err pulse, beat discarded, slot<=0,
//         go HUNT (locked drops next cycle).
//  Output update: on the edge that accepts slot 3, o0..o2 load from capture regs and
//   o3 loads din directly; out_valid=1 for exactly that following cycle. Latency:
//   slot-3 beat at edge N -> o0..o3 and out_valid visible after edge N (1 clk).
//   o0..o3 hold between frames; never partially updated.
//  Back-to-back frames at full rate (din_valid=1 every cycle) give out_valid every
//   4th cycle. sync_err and out_valid never both 1 in the same cycle.
//  slot output reflects the counter register; slot=0 whenever locked=0.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> all outputs 0 immediately, state HUNT, slot=0.
//  2 Lock+frame: beats (sync=1,1),(0,0),(0,1),(0,0) [WIDTH=1] -> one cycle after 4th
//    beat o0=1,o1=0,o2=1,o3=0, out_valid=1 for 1 cycle, locked=1.
//  3 Gapped valid: same frame with din_valid=0 cycles between beats -> identical
//    o0..o3, single out_valid; slot holds through gaps.
//  4 Early sync: frame_sync=1 on slot 2 -> sync_err 1 cycle, no out_valid, next 3
//    beats complete new frame with that beat as o0.
//  5 Missing sync: slot-0 beat with frame_sync=0 -> sync_err, locked=0, then data
//    ignored until next frame_sync; o0..o3 retain last good frame.
//  6 Full-rate: 3 consecutive frames, din_valid=1 every cycle -> out_valid at cycles
//    4,8,12 after lock beat; each frame's values correct.

Source files
------------

// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
// Receive-side 1:4 time-division demultiplexer. Each accepted beat
// (din_valid=1) carries one slot, and four slots make up a frame. Slot 0 of
// every frame is marked by frame_sync. A 2-bit slot counter tracks which slot
// the next beat should be. When a frame is complete, all four channel outputs
// are loaded together in a single update.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   din_valid   in   beat qualifier for din / frame_sync
//   din         in   slot data [WIDTH-1:0]
//   frame_sync  in   marks slot 0 (qualified by din_valid)
//   o0..o3      out  channel samples of the last complete frame
//   out_valid   out  1-cycle pulse when o0..o3 have just been updated
//   slot        out  slot index expected on the next beat
//   locked      out  high while frame alignment is held
//   sync_err    out  1-cycle pulse on a frame-alignment error
//
// state  | meaning
// -------+-------------------------------------------------------------
// HUNT   | waiting for a beat with frame_sync to start a frame
// LOCKED | aligned; r_slot holds the slot expected on the next beat
// -----------------------------------------------------------------------------
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic             out_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_slot;
    logic [WIDTH-1:0] r_cap0;
    logic [WIDTH-1:0] r_cap1;
    logic [WIDTH-1:0] r_cap2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= HUNT;
            r_slot    <= 2'd0;
            r_cap0    <= '0;
            r_cap1    <= '0;
            r_cap2    <= '0;
            o0        <= '0;
            o1        <= '0;
            o2        <= '0;
            o3        <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            // Both pulses are one cycle wide. They clear even on idle cycles.
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    HUNT: begin
                        if (frame_sync) begin
                            r_cap0  <= din;
                            r_slot  <= 2'd1;
                            r_state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (r_slot == 2'd0) begin
                            if (frame_sync) begin
                                r_cap0 <= din;
                                r_slot <= 2'd1;
                            end else begin
                                // Missing sync: drop the beat and go back to hunting.
                                sync_err <= 1'b1;
                                r_slot   <= 2'd0;
                                r_state  <= HUNT;
                            end
                        end else if (frame_sync) begin
                            // Early sync: drop the partial frame and restart it on this beat.
                            sync_err <= 1'b1;
                            r_cap0   <= din;
                            r_slot   <= 2'd1;
                        end else begin
                            case (r_slot)
                                2'd1: r_cap1 <= din;
                                2'd2: r_cap2 <= din;
                                default: begin
                                    // Slot 3 takes din directly, so the frame
                                    // lands on all outputs in the same cycle.
                                    o0        <= r_cap0;
                                    o1        <= r_cap1;
                                    o2        <= r_cap2;
                                    o3        <= din;
                                    out_valid <= 1'b1;
                                end
                            endcase
                            r_slot <= r_slot + 2'd1;
                        end
                    end
                    default: begin
                        r_state <= HUNT;
                        r_slot  <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign slot   = r_slot;
    assign locked = (r_state == LOCKED);

endmodule
